// File: rtl/region_sched_pkg.sv
// Shared types and default sizing for the region scheduler.
package region_sched_pkg;

  localparam int N_REQ_DEFAULT     = 4;
  localparam int AW_DEFAULT        = 3;
  localparam int DW_DEFAULT        = 8;
  localparam int NBA_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    NBA    = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/region_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last grantee.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] eligible,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  masked;
  logic          found;

  // Search from ptr upward first, then wrap to the lowest eligible requester.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    ptr_next = ptr;
    hi_mask  = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    masked = eligible & hi_mask;
    for (int i = 0; i < N; i++) begin
      if (enable && !found && masked[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (enable && !found && eligible[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Advance the priority pointer only when a grant is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/region_sched.sv
// Time-step scheduler: blocking updates hit the store at once, nonblocking
// updates are queued and applied in push order when the active region drains.
module region_sched
  import region_sched_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int NBA_DEPTH = NBA_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_start,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_nba,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                step_done,
  output logic                busy
);

  localparam int NVAR  = 2 ** AW;
  localparam int FPW   = (NBA_DEPTH > 1) ? $clog2(NBA_DEPTH) : 1;
  localparam int FSIZE = 2 ** FPW;

  sched_state_t state;
  sched_state_t state_next;

  logic [DW-1:0]  store     [NVAR];
  logic [AW-1:0]  fifo_addr [FSIZE];
  logic [DW-1:0]  fifo_data [FSIZE];
  logic [FPW-1:0] wr_ptr;
  logic [FPW-1:0] rd_ptr;
  logic [FPW:0]   count;
  logic           fifo_full;
  logic           fifo_empty;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             arb_en;
  logic             gnt_any;
  logic             gnt_nba;
  logic [AW-1:0]    gnt_addr;
  logic [DW-1:0]    gnt_data;
  logic             push;
  logic             blk_wr;
  logic             pop;

  assign fifo_full  = (count == (FPW + 1)'(NBA_DEPTH));
  assign fifo_empty = (count == '0);
  assign eligible   = req_valid & ~(req_nba & {N_REQ{fifo_full}});
  assign arb_en     = (state == ACTIVE);
  assign req_ready  = grant;
  assign rd_data    = store[rd_addr];
  assign busy       = (state != IDLE);

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .enable   (arb_en),
    .grant    (grant)
  );

  // Pick out the granted requester's payload.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_nba  = 1'b0;
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_any  = 1'b1;
        gnt_nba  = req_nba[i];
        gnt_addr = req_addr[i*AW +: AW];
        gnt_data = req_data[i*DW +: DW];
      end
    end
  end

  assign push   = gnt_any & gnt_nba;
  assign blk_wr = gnt_any & ~gnt_nba;
  assign pop    = (state == NBA) & ~fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and step_done decode.
  always_comb begin
    state_next = state;
    step_done  = 1'b0;
    case (state)
      IDLE: begin
        if (step_start) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (eligible == '0) state_next = NBA;
      end
      NBA: begin
        if (fifo_empty) state_next = (|req_valid) ? ACTIVE : DONE;
      end
      DONE: begin
        step_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Variable store: blocking writes in ACTIVE, FIFO drain in NBA (never both).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NVAR; i++) begin
        store[i] <= '0;
      end
    end else if (blk_wr) begin
      store[gnt_addr] <= gnt_data;
    end else if (pop) begin
      store[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
    end
  end

  // FIFO storage; contents are irrelevant while count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= gnt_addr;
      fifo_data[wr_ptr] <= gnt_data;
    end
  end

  // FIFO pointers and occupancy; reset discards whatever was queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_region_sched.sv
// Directed bench for region_sched with hand-computed expectations.
module tb_region_sched;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_start;
  logic [3:0]  req_valid;
  logic [3:0]  req_nba;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        step_done;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] pq [NR][8];
  int          head [NR];
  int          tail [NR];
  logic [3:0]  xfer_s;
  int          cycle      = 0;
  int          done_count = 0;
  int          glog_id  [$];
  int          glog_cyc [$];
  int          exp_c [6] = '{0, 1, 2, 3, 3, 0};
  int          g0;
  int          d0;

  region_sched u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_start (step_start),
    .req_valid  (req_valid),
    .req_nba    (req_nba),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .step_done  (step_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter for grant timing.
  always @(posedge clk) cycle++;

  // Observe transfers, grants and step_done away from the clock edge.
  always @(negedge clk) begin
    xfer_s = req_valid & req_ready;
    if (step_done) done_count++;
    for (int i = 0; i < NR; i++) begin
      if (xfer_s[i]) begin
        glog_id.push_back(i);
        glog_cyc.push_back(cycle);
      end
    end
  end

  // Requester model: hold each queued request until it transfers.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (!rst_n) head[i] = tail[i];
      else if (xfer_s[i] && head[i] < tail[i]) head[i]++;
      if (head[i] < tail[i]) begin
        req_valid[i]         = 1'b1;
        req_nba[i]           = pq[i][head[i]][11];
        req_addr[i*3 +: 3]   = pq[i][head[i]][10:8];
        req_data[i*8 +: 8]   = pq[i][head[i]][7:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_nba[i]           = 1'b0;
        req_addr[i*3 +: 3]   = 3'd0;
        req_data[i*8 +: 8]   = 8'd0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic nba,
                               input logic [2:0] addr, input logic [7:0] data);
    pq[r][tail[r]] = {nba, addr, data};
    tail[r]++;
  endtask

  task automatic checkVar(input string tag, input logic [2:0] a, input logic [7:0] exp_d);
    rd_addr = a;
    #1;
    checkOutput(tag, 32'(rd_data), 32'(exp_d));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n      = 1'b0;
    step_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic startStep();
    step_start = 1'b1;
    g0 = glog_id.size();
    d0 = done_count;
    @(posedge clk);
    #3;
    step_start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int k = 0; k < budget && seen == 0; k++) begin
      @(negedge clk);
      if (step_done) seen = 1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst_n      = 1'b0;
    step_start = 1'b0;
    rd_addr    = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(step_done), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkVar("rst_store2", 3'd2, 8'h00);

    $display("[TB] blocking then NBA to same address");
    @(posedge clk);
    #3;
    applyStimulus(0, 1'b0, 3'd2, 8'h11);
    applyStimulus(1, 1'b1, 3'd2, 8'h22);
    rd_addr = 3'd2;
    startStep();
    @(negedge clk);
    checkOutput("a_grant0", 32'(req_ready), 32'h1);
    checkOutput("a_pre_write", 32'(rd_data), 32'h00);
    @(negedge clk);
    checkOutput("a_grant1", 32'(req_ready), 32'h2);
    checkOutput("a_blk_visible", 32'(rd_data), 32'h11);
    @(negedge clk);
    checkOutput("a_active_busy", 32'(busy), 32'd1);
    checkOutput("a_active_hold", 32'(rd_data), 32'h11);
    @(negedge clk);
    checkOutput("a_nba_pre", 32'(rd_data), 32'h11);
    @(negedge clk);
    checkOutput("a_nba_post", 32'(rd_data), 32'h22);
    @(negedge clk);
    checkOutput("a_done_pulse", 32'(step_done), 32'd1);
    @(negedge clk);
    checkOutput("a_done_low", 32'(step_done), 32'd0);
    checkOutput("a_idle", 32'(busy), 32'd0);
    #1;
    checkOutput("a_done_count", 32'(done_count - d0), 32'd1);

    $display("[TB] round-robin fairness");
    doReset();
    @(posedge clk);
    #3;
    for (int r = 0; r < NR; r++) begin
      applyStimulus(r, 1'b0, 3'(r), 8'(8'h30 + r));
      applyStimulus(r, 1'b0, 3'(r + 4), 8'(8'h40 + r));
    end
    startStep();
    waitDone("b_done", 40);
    #1;
    checkOutput("b_grants", 32'(glog_id.size() - g0), 32'd8);
    if (glog_id.size() - g0 >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checkOutput("b_order", 32'(glog_id[g0 + k]), 32'(k % 4));
      end
      for (int k = 1; k < 5; k++) begin
        checkOutput("b_consec", 32'(glog_cyc[g0 + k] - glog_cyc[g0 + k - 1]), 32'd1);
      end
    end
    for (int r = 0; r < NR; r++) begin
      checkVar("b_store_lo", 3'(r), 8'(8'h30 + r));
      checkVar("b_store_hi", 3'(r + 4), 8'(8'h40 + r));
    end

    $display("[TB] FIFO full with blocking bypass");
    doReset();
    @(posedge clk);
    #3;
    applyStimulus(0, 1'b1, 3'd0, 8'hA0);
    applyStimulus(0, 1'b1, 3'd4, 8'hA4);
    applyStimulus(1, 1'b1, 3'd1, 8'hA1);
    applyStimulus(2, 1'b1, 3'd2, 8'hA2);
    applyStimulus(3, 1'b1, 3'd3, 8'hA3);
    applyStimulus(3, 1'b0, 3'd7, 8'hB7);
    startStep();
    waitDone("c_done", 60);
    #1;
    checkOutput("c_grants", 32'(glog_id.size() - g0), 32'd6);
    if (glog_id.size() - g0 >= 6) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput("c_order", 32'(glog_id[g0 + k]), 32'(exp_c[k]));
      end
      checkOutput("c_blk_while_full", 32'(glog_cyc[g0 + 4] - glog_cyc[g0 + 3]), 32'd1);
      checkOutput("c_reiter_gap", 32'(glog_cyc[g0 + 5] - glog_cyc[g0 + 4]), 32'd7);
    end
    checkVar("c_store0", 3'd0, 8'hA0);
    checkVar("c_store1", 3'd1, 8'hA1);
    checkVar("c_store2", 3'd2, 8'hA2);
    checkVar("c_store3", 3'd3, 8'hA3);
    checkVar("c_store4", 3'd4, 8'hA4);
    checkVar("c_store7", 3'd7, 8'hB7);
    checkOutput("c_done_count", 32'(done_count - d0), 32'd1);

    $display("[TB] duplicate NBA address and ignored step_start");
    doReset();
    rd_addr = 3'd5;
    @(posedge clk);
    #3;
    applyStimulus(0, 1'b1, 3'd5, 8'h01);
    applyStimulus(1, 1'b1, 3'd5, 8'h02);
    startStep();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    step_start = 1'b1;
    @(negedge clk);
    checkOutput("d_in_nba", 32'(busy), 32'd1);
    checkOutput("d_nba_pre", 32'(rd_data), 32'h00);
    @(posedge clk);
    #3;
    step_start = 1'b0;
    @(negedge clk);
    checkOutput("d_first_pop", 32'(rd_data), 32'h01);
    @(negedge clk);
    checkOutput("d_last_wins", 32'(rd_data), 32'h02);
    waitDone("d_done", 10);
    repeat (10) @(negedge clk);
    checkOutput("d_no_restart", 32'(busy), 32'd0);
    checkVar("d_final", 3'd5, 8'h02);
    checkOutput("d_done_count", 32'(done_count - d0), 32'd1);

    $display("[TB] reset during NBA drain");
    doReset();
    @(posedge clk);
    #3;
    applyStimulus(0, 1'b0, 3'd6, 8'h66);
    applyStimulus(1, 1'b1, 3'd1, 8'h11);
    applyStimulus(2, 1'b1, 3'd2, 8'h22);
    applyStimulus(3, 1'b1, 3'd3, 8'h33);
    startStep();
    repeat (6) @(negedge clk);
    checkOutput("e_busy_nba", 32'(busy), 32'd1);
    checkVar("e_blk_before", 3'd6, 8'h66);
    rst_n = 1'b0;
    #1;
    checkOutput("e_rst_busy", 32'(busy), 32'd0);
    checkOutput("e_rst_done", 32'(step_done), 32'd0);
    checkVar("e_rst_store6", 3'd6, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("e_after_busy", 32'(busy), 32'd0);
    checkVar("e_store1", 3'd1, 8'h00);
    checkVar("e_store2", 3'd2, 8'h00);
    checkVar("e_store3", 3'd3, 8'h00);
    checkOutput("e_no_done", 32'(done_count - d0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
